// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants, request payload and FSM state types for the
// instruction encoder/loader and its decoder counterpart.
package rv32_pkg;

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned AWIDTH = 32;
    localparam int unsigned CWIDTH = 16;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_SB = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_UJ = 3'd5;

    localparam logic [DWIDTH-1:0] NOP = 32'h0000_0013;

    // Field LSB positions within an instruction word
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // True when v is representable as a signed value of the given bit width
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] s;
        s = $signed(v) >>> (bits - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Request and IMEM-write bundle of the instruction encoder/loader.
interface inst_encoder_loader_if;
    import rv32_pkg::*;

    logic              i_start;
    logic [AWIDTH-1:0] i_base_addr;
    logic              i_valid;
    logic              o_ready;
    logic              i_last;
    logic [2:0]        i_fmt;
    logic [6:0]        i_opcode;
    logic [4:0]        i_rd;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [2:0]        i_funct3;
    logic [6:0]        i_funct7;
    logic [31:0]       i_imm;
    logic              o_mem_we;
    logic [AWIDTH-1:0] o_mem_addr;
    logic [DWIDTH-1:0] o_mem_wdata;
    logic              i_mem_ready;
    logic [CWIDTH-1:0] o_count;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_start, i_base_addr, i_valid, i_last, i_fmt, i_opcode, i_rd, i_rs1,
               i_rs2, i_funct3, i_funct7, i_imm, i_mem_ready,
        output o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_done, o_err
    );

    modport master (
        output i_start, i_base_addr, i_valid, i_last, i_fmt, i_opcode, i_rd, i_rs1,
               i_rs2, i_funct3, i_funct7, i_imm, i_mem_ready,
        input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_done, o_err
    );

endinterface

// File: rtl/inst_encoder_loader_packer.sv
// Combinational RV32I field-to-word packer. INST_ENCODER_IMM_CHECK_EN adds
// immediate range/alignment checking on range_err_c.
module inst_packer
    import rv32_pkg::*;
(
    input  enc_req_t          req,
    output logic [DWIDTH-1:0] word_c,
    output logic              illegal_c,
    output logic              range_err_c
);

    always_comb begin
        word_c      = NOP;
        illegal_c   = 1'b0;
        range_err_c = 1'b0;
        case (req.fmt)
            FMT_R:  word_c = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            FMT_I:  word_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            FMT_S:  word_c = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            FMT_SB: word_c = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                              req.imm[4:1], req.imm[11], req.opcode};
            FMT_U:  word_c = {req.imm[31:12], req.rd, req.opcode};
            FMT_UJ: word_c = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                              req.rd, req.opcode};
            default: illegal_c = 1'b1;
        endcase
`ifdef INST_ENCODER_IMM_CHECK_EN
        case (req.fmt)
            FMT_I, FMT_S: range_err_c = !fits_signed(req.imm, 12);
            FMT_SB:       range_err_c = !fits_signed(req.imm, 13) || req.imm[0];
            FMT_U:        range_err_c = (req.imm[11:0] != 12'd0);
            FMT_UJ:       range_err_c = !fits_signed(req.imm, 21) || req.imm[0];
            default:      range_err_c = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Streaming RV32I encoder that writes packed words to consecutive IMEM addresses.
// Optional immediate checking via INST_ENCODER_IMM_CHECK_EN (see inst_packer).
module inst_encoder_loader
    import rv32_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    inst_encoder_loader_if.slave  bus
);

    state_e            state_q, state_d;
    logic              buf_valid_q, buf_last_q, last_seen_q, err_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [AWIDTH-1:0] addr_q;
    logic [CWIDTH-1:0] count_q;
    logic              ready_c, done_c, accept_c, write_done_c, start_go_c;
    enc_req_t          req_c;
    logic [DWIDTH-1:0] pack_word_c;
    logic              pack_illegal_c, pack_range_err_c;

    assign req_c = '{fmt: bus.i_fmt, opcode: bus.i_opcode, rd: bus.i_rd, rs1: bus.i_rs1,
                     rs2: bus.i_rs2, funct3: bus.i_funct3, funct7: bus.i_funct7, imm: bus.i_imm};

    inst_packer u_packer (
        .req         (req_c),
        .word_c      (pack_word_c),
        .illegal_c   (pack_illegal_c),
        .range_err_c (pack_range_err_c)
    );

    assign accept_c     = bus.i_valid && ready_c;
    assign write_done_c = buf_valid_q && bus.i_mem_ready;
    assign start_go_c   = (state_q == ST_IDLE) && bus.i_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_start) state_d = ST_RUN;
            ST_RUN:  if (write_done_c && buf_last_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is closed once the last request is in, until the FSM leaves RUN
    always_comb begin
        ready_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_RUN:  ready_c = !last_seen_q && (!buf_valid_q || bus.i_mem_ready);
            ST_DONE: done_c  = 1'b1;
            default: ;
        endcase
    end

    // Single-entry output buffer: a new accept may reload it as the old word retires
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_valid_q <= 1'b0;
            buf_last_q  <= 1'b0;
            wdata_q     <= '0;
        end else if (accept_c) begin
            buf_valid_q <= 1'b1;
            buf_last_q  <= bus.i_last;
            wdata_q     <= pack_word_c;
        end else if (write_done_c) begin
            buf_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
        end else if (start_go_c) begin
            addr_q      <= bus.i_base_addr;
            count_q     <= '0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            if (write_done_c) begin
                addr_q  <= addr_q + AWIDTH'(4);
                count_q <= count_q + CWIDTH'(1);
            end
            if (accept_c) begin
                last_seen_q <= last_seen_q | bus.i_last;
                if (pack_illegal_c || pack_range_err_c) err_q <= 1'b1;
            end
        end
    end

    assign bus.o_ready     = ready_c;
    assign bus.o_done      = done_c;
    assign bus.o_mem_we    = buf_valid_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_count     = count_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed, table-driven bench for inst_encoder_loader.
module tb_inst_encoder_loader;
    import rv32_pkg::*;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

`ifdef INST_ENCODER_IMM_CHECK_EN
    localparam logic IMMCHK = 1'b1;
`else
    localparam logic IMMCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    inst_encoder_loader_if bus();

    inst_encoder_loader dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v, input logic last);
        bus.i_valid  = 1'b1;
        bus.i_last   = last;
        bus.i_fmt    = v.fmt;
        bus.i_opcode = v.op;
        bus.i_rd     = v.rd;
        bus.i_rs1    = v.rs1;
        bus.i_rs2    = v.rs2;
        bus.i_funct3 = v.f3;
        bus.i_funct7 = v.f7;
        bus.i_imm    = v.imm;
    endtask

    task automatic do_start(input logic [31:0] base);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        @(negedge clk);
        bus.i_start = 1'b0;
        #1;
        check("start_count", 32'(bus.o_count), 32'd0);
        check("start_err", 32'(bus.o_err), 32'd0);
    endtask

    // mode 0: IMEM always ready; mode 1: ready pattern 1,0,0,1 repeating
    task automatic run_stream(input int first, input int n, input logic [31:0] base,
                              input int mode, input logic noise);
        int idx, wr, cyc, first_cyc, last_cyc, dones;
        logic mready, acc, model_buf, last_acc, stalled, exp_err, exp_rdy;
        logic [31:0] p_addr, p_data;
        idx = 0; wr = 0; cyc = 0; first_cyc = 0; last_cyc = 0; dones = 0;
        model_buf = 1'b0; last_acc = 1'b0; stalled = 1'b0; exp_err = 1'b0;
        p_addr = '0; p_data = '0;
        do_start(base);
        while (wr < n && cyc < 200) begin
            @(negedge clk);
            mready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            bus.i_mem_ready = mready;
            bus.i_start     = noise;
            bus.i_base_addr = noise ? 32'hDEAD_0000 : base;
            if (idx < n) drive(vecs[first + idx], idx == n - 1);
            else         bus.i_valid = 1'b0;
            #1;
            exp_rdy = !last_acc && (!model_buf || mready);
            check("o_ready", 32'(bus.o_ready), 32'(exp_rdy));
            check("o_mem_we", 32'(bus.o_mem_we), 32'(model_buf));
            if (stalled) begin
                check("hold_addr", bus.o_mem_addr, p_addr);
                check("hold_data", bus.o_mem_wdata, p_data);
            end
            if (bus.o_mem_we && mready && wr < n) begin
                check("wr_addr", bus.o_mem_addr, base + 32'(4 * wr));
                check("wr_data", bus.o_mem_wdata, vecs[first + wr].exp_word);
                if (wr == 0) first_cyc = cyc;
                last_cyc = cyc;
                wr++;
            end
            stalled = bus.o_mem_we && !mready;
            p_addr  = bus.o_mem_addr;
            p_data  = bus.o_mem_wdata;
            acc     = bus.i_valid && bus.o_ready;
            if (acc) begin
                model_buf = 1'b1;
                if (idx == n - 1) last_acc = 1'b1;
                exp_err = exp_err | vecs[first + idx].exp_err;
                idx++;
            end else if (model_buf && mready) begin
                model_buf = 1'b0;
            end
            if (bus.o_done) dones++;
            cyc++;
            @(posedge clk);
        end
        check("write_total", 32'(wr), 32'(n));
        if (mode == 0) check("throughput_span", 32'(last_cyc - first_cyc), 32'(n - 1));
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
        #1;
        check("done_high", 32'(bus.o_done), 32'd1);
        check("final_count", 32'(bus.o_count), 32'(n));
        check("final_err", 32'(bus.o_err), 32'(exp_err));
        check("final_we", 32'(bus.o_mem_we), 32'd0);
        if (bus.o_done) dones++;
        @(negedge clk);
        #1;
        if (bus.o_done) dones++;
        check("done_pulses", 32'(dones), 32'd1);
        check("idle_ready", 32'(bus.o_ready), 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 1'b0};
        vecs[1] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         32'h0020_81B3, 1'b0};
        vecs[2] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0};
        vecs[3] = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         32'h0020_8463, 1'b0};
        vecs[4] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16,        32'h0100_00EF, 1'b0};
        vecs[5] = '{3'd7, 7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         32'h0000_0013, 1'b1};
        vecs[6] = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,         32'h0020_8163, IMMCHK};
        vecs[7] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        vecs[8] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        vecs[9] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFF9F_F06F, 1'b0};

        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_valid = 1'b0; bus.i_last = 1'b0;
        bus.i_fmt = '0; bus.i_opcode = '0; bus.i_rd = '0; bus.i_rs1 = '0; bus.i_rs2 = '0;
        bus.i_funct3 = '0; bus.i_funct7 = '0; bus.i_imm = '0; bus.i_mem_ready = 1'b0;
        #12;
        check("rst_we", 32'(bus.o_mem_we), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        check("rst_addr", bus.o_mem_addr, 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_stream(0, 1, 32'h0000_0100, 0, 1'b0);
        run_stream(1, 4, 32'h0000_0200, 0, 1'b0);
        run_stream(1, 4, 32'h0000_0300, 1, 1'b1);
        run_stream(5, 1, 32'h0000_0400, 0, 1'b0);
        run_stream(6, 1, 32'h0000_0480, 0, 1'b0);
        run_stream(7, 3, 32'hFFFF_FFFC, 1, 1'b0);

        // Reset while a write is stalled
        do_start(32'h0000_0500);
        @(negedge clk);
        bus.i_mem_ready = 1'b1;
        drive(vecs[1], 1'b0);
        @(negedge clk);
        drive(vecs[0], 1'b1);
        @(negedge clk);
        bus.i_valid     = 1'b0;
        bus.i_mem_ready = 1'b0;
        #1;
        check("pre_rst_we", 32'(bus.o_mem_we), 32'd1);
        check("pre_rst_count", 32'(bus.o_count), 32'd1);
        check("pre_rst_addr", bus.o_mem_addr, 32'h0000_0504);
        check("pre_rst_data", bus.o_mem_wdata, vecs[0].exp_word);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(bus.o_mem_we), 32'd0);
        check("mid_rst_count", 32'(bus.o_count), 32'd0);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(bus.o_ready), 32'd0);
        check("post_rst_we", 32'(bus.o_mem_we), 32'd0);
        run_stream(0, 1, 32'h0000_0600, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Streaming RISC-V RV32I instruction encoder and instruction-memory writer; the write-side counterpart of the instruction decoder.
- Accepts field-level encode requests, packs them into 32-bit words, and writes the words to consecutive IMEM addresses.
- Sits between the debug/boot loader and the IMEM write port, so test programs can be built from field tuples in-system.

Parameters:
- DWIDTH, 32, instruction/data word width (fixed at 32 for RV32I).
- AWIDTH, 32, IMEM byte-address width.
- CWIDTH, 16, width of the written-word counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_start  input  1  in IDLE: latch i_base_addr, enter RUN.
- i_base_addr  input  AWIDTH  first write byte address.
- i_valid  input  1  encode request valid.
- o_ready  output  1  request accepted when i_valid && o_ready.
- i_last  input  1  marks the final request of a program.
- i_fmt  input  3  format: 0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ; 6 and 7 are illegal.
- i_opcode  input  7  opcode.
- i_rd, i_rs1, i_rs2  input  5 each  register fields.
- i_funct3  input  3  funct3.
- i_funct7  input  7  funct7.
- i_imm  input  32  immediate; byte offset for SB/UJ.
- o_mem_we  output  1  IMEM write valid.
- o_mem_addr  output  AWIDTH  IMEM byte address.
- o_mem_wdata  output  DWIDTH  encoded word.
- i_mem_ready  input  1  IMEM accepts the write this cycle.
- o_count  output  CWIDTH  words written since i_start.
- o_done  output  1  one-cycle pulse after the last word is written.
- o_err  output  1  sticky error flag; cleared on i_start.

Behaviour:
- Reset: all outputs 0; state IDLE; internal buffer empty.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on i_start. In the same cycle: addr<=i_base_addr, o_count<=0, o_err<=0.
  - RUN -> DONE when the word tagged i_last is accepted by IMEM (o_mem_we && i_mem_ready).
  - DONE -> IDLE after one cycle; o_done=1 only while in DONE.
  - i_start is ignored in RUN and DONE.
- Buffering: single output register.
  - o_ready = (state==RUN) && (!buf_valid || i_mem_ready).
  - Latency: a request accepted in cycle N gives o_mem_we=1 in cycle N+1.
  - o_mem_we, o_mem_addr and o_mem_wdata hold stable until i_mem_ready.
  - Accept and write-complete in the same cycle: the buffer reloads. Full throughput is 1 word/cycle.
  - After an i_last request is accepted, o_ready=0 until the FSM returns to IDLE.
- Address and count: on each completed write, addr += 4 and o_count += 1. Both wrap modulo 2^AWIDTH and 2^CWIDTH respectively.
- Packing (bit order MSB..LSB):
  - R: f7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - SB: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - UJ: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Illegal fmt (6/7): write NOP 0x00000013 and set o_err.
- Reset mid-operation: the buffered write is discarded (o_mem_we drops asynchronously), counters clear, state returns to IDLE.

Optional Feature:
- Macro: INST_ENCODER_IMM_CHECK_EN.
- Defined, o_err is also set by any of:
  - I/S immediate outside signed 12-bit range.
  - SB immediate outside signed 13-bit range.
  - UJ immediate outside signed 21-bit range.
  - SB/UJ immediate with imm[0]=1.
  - U immediate with imm[11:0] != 0.
  The word is still written, with truncated fields.
- Undefined: immediates are truncated silently; o_err reflects illegal fmt only.

Decomposition:
- Shared package (rv32_pkg):
  - format codes FMT_R..FMT_UJ.
  - NOP constant 32'h00000013.
  - field bit-position constants, shared with the decoder.
- Sub-module inst_packer: purely combinational field-to-word packing (fmt + fields -> word, illegal flag, range-error flag).
- The top level holds the FSM, buffer and counters.

Test Plan:
- i_start with base 0x100; ADDI x1,x0,5 (fmt I, op 0x13, imm 5) with i_last -> write 0x00500093 @0x100; o_count=1; o_done pulses once.
- Stream ADD x3,x1,x2 / SW x2,8(x1) / BEQ x1,x2,+8 / JAL x1,+16 back-to-back with i_mem_ready=1 -> 0x002081B3, 0x0020A423, 0x00208463, 0x010000EF at consecutive addresses, one per cycle.
- Same stream with i_mem_ready toggling 1,0,0,1,... -> no loss or duplication; write outputs stable while stalled; o_ready follows the buffer rule.
- fmt=7 request -> writes 0x00000013, o_err=1; the next i_start clears o_err.
- Base 0xFFFFFFFC with two requests -> writes at 0xFFFFFFFC then 0x00000000.
- i_rst asserted while a write is stalled -> o_mem_we=0 immediately, o_count=0, state IDLE. With INST_ENCODER_IMM_CHECK_EN: SB imm=3 sets o_err.
